// File: rtl/fir_mac_sequencer.sv
// fir_mac_sequencer: time-multiplexed FIR, one signed MAC stepped over TAPS coefficients per sample.
module fir_mac_sequencer #(
  parameter int TAPS   = 8,
  parameter int DATA_W = 8,
  parameter int COEF_W = 8,
  parameter int OUT_W  = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic signed [DATA_W-1:0]    data_in,
  input  logic                        coef_we,
  input  logic [$clog2(TAPS)-1:0]     coef_addr,
  input  logic signed [COEF_W-1:0]    coef_data,
  output logic                        coef_err,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [OUT_W-1:0]     data_out
);
  localparam int AW    = $clog2(TAPS);
  localparam int PW    = DATA_W + COEF_W;
  localparam int ACC_W = PW + AW;
  localparam logic signed [ACC_W-1:0] SAT_HI = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_LO = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;
  state_t state, state_n;
  logic signed [DATA_W-1:0] hist [TAPS];
  logic signed [COEF_W-1:0] coef [TAPS];
  logic [AW-1:0] wr_ptr, k;
  logic signed [ACC_W-1:0] acc;
  logic signed [PW-1:0] prod;
  logic accept;
  assign accept    = state == IDLE && in_valid;
  assign in_ready  = state == IDLE;
  assign out_valid = state == OUT;
  // wr_ptr already points past the newest sample while in MAC
  assign prod      = hist[wr_ptr - AW'(1) - k] * coef[k];
  assign data_out  = acc > SAT_HI ? OUT_W'(SAT_HI) : acc < SAT_LO ? OUT_W'(SAT_LO) : acc[OUT_W-1:0];
  always_ff @(posedge clk)
    if (reset) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    state_n = state == IDLE ? (in_valid ? MAC : IDLE)
            : state == MAC  ? (k == AW'(TAPS-1) ? OUT : MAC)
            : (out_ready ? IDLE : OUT);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      k        <= '0;
      acc      <= '0;
      coef_err <= 1'b0;
      for (int i = 0; i < TAPS; i++) begin
        hist[i] <= '0;
        coef[i] <= '0;
      end
    end else begin
      if (coef_we && state == IDLE) coef[coef_addr] <= coef_data;
      if (coef_we && state != IDLE) coef_err <= 1'b1;
      if (accept) begin
        hist[wr_ptr] <= data_in;
        wr_ptr       <= wr_ptr + AW'(1);
        acc          <= '0;
        k            <= '0;
      end else if (state == MAC) begin
        acc <= acc + {{AW{prod[PW-1]}}, prod};
        k   <= k + AW'(1);
      end
    end
  end
endmodule

// File: tb/tb_fir_mac_sequencer.sv
// tb_fir_mac_sequencer: random and directed stimulus checked cycle by cycle against a sum-of-products model.
module tb_fir_mac_sequencer;
  localparam int TAPS = 8;
  logic clk = 0, reset = 0, in_valid = 0, coef_we = 0, out_ready = 1;
  logic signed [7:0] data_in = 0, coef_data = 0;
  logic [2:0] coef_addr = 0;
  logic in_ready, coef_err, out_valid;
  logic signed [15:0] data_out;
  fir_mac_sequencer #(.TAPS(TAPS), .DATA_W(8), .COEF_W(8), .OUT_W(16)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .data_in(data_in),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data), .coef_err(coef_err),
    .out_valid(out_valid), .out_ready(out_ready), .data_out(data_out));
  always #5 clk = ~clk;
  int tests = 0, fails = 0, cyc = 0;
  longint mc [TAPS];
  longint xs[$], got[$], mres[$];
  int acc_cyc[$], out_cyc[$];
  int m_cnt = 0;
  bit m_out = 0, m_err = 0, m_init = 0, m_idle;
  longint m_exp = 0;
  function automatic longint sat(longint v);
    return v > 32767 ? 32767 : v < -32768 ? -32768 : v;
  endfunction
  function automatic longint fir();
    longint s = 0;
    int n = xs.size() - 1;
    for (int j = 0; j < TAPS; j++) if (n - j >= 0) s += mc[j] * xs[n-j];
    return sat(s);
  endfunction
  task automatic chk(string nm, logic signed [63:0] g, logic signed [63:0] e);
    tests++;
    if (g !== e) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, g, e);
    end
  endtask
  // reference model: a sample becomes a result TAPS edges after acceptance
  initial forever begin
    @(posedge clk);
    cyc++;
    if (reset) begin
      m_init = 1; m_cnt = 0; m_out = 0; m_err = 0; m_exp = 0;
      xs.delete();
      foreach (mc[i]) mc[i] = 0;
    end else if (m_init) begin
      m_idle = m_cnt == 0 && !m_out;
      if (coef_we) begin
        if (m_idle) mc[coef_addr] = coef_data;
        else m_err = 1;
      end
      if (m_idle) begin
        if (in_valid) begin
          xs.push_back(data_in);
          m_exp = fir();
          m_cnt = TAPS;
          acc_cyc.push_back(cyc);
        end
      end else if (m_cnt > 0) begin
        m_cnt--;
        if (m_cnt == 0) m_out = 1;
      end else if (out_ready) begin
        m_out = 0;
        mres.push_back(m_exp);
        got.push_back(data_out);
        out_cyc.push_back(cyc);
      end
    end
  end
  initial forever begin
    @(negedge clk);
    if (m_init && !reset) begin
      chk("in_ready", in_ready, m_cnt == 0 && !m_out);
      chk("out_valid", out_valid, m_out);
      chk("coef_err", coef_err, m_err);
      if (m_out) chk("data_out", data_out, m_exp);
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    reset = 1; in_valid = 0; coef_we = 0; out_ready = 1;
    tick(); tick();
    reset = 0;
    got.delete(); mres.delete(); acc_cyc.delete(); out_cyc.delete();
  endtask
  task automatic wcoef(int a, int d);
    coef_we = 1; coef_addr = 3'(a); coef_data = 8'(d);
    tick();
    coef_we = 0;
  endtask
  task automatic wait_idle();
    int n = 0;
    while (!in_ready && n < 100) begin tick(); n++; end
    if (!in_ready) chk("idle_timeout", in_ready, 1);
  endtask
  task automatic send(int x);
    wait_idle();
    in_valid = 1; data_in = 8'(x);
    tick();
    in_valid = 0;
  endtask
  task automatic send_w(int x, int a, int d);
    wait_idle();
    in_valid = 1; data_in = 8'(x);
    coef_we = 1; coef_addr = 3'(a); coef_data = 8'(d);
    tick();
    in_valid = 0; coef_we = 0;
  endtask
  task automatic wait_out(int want);
    int n = 0;
    while (got.size() < want && n < 300) begin tick(); n++; end
    if (got.size() < want) chk("out_timeout", got.size(), want);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    longint sums [8] = '{10, 30, 60, 100, 150, 210, 280, 360};
    longint imp [8]  = '{3, -2, 5, 0, 0, 0, 0, 7};
    int n;
    do_reset();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_data_out", data_out, 0);
    chk("rst_coef_err", coef_err, 0);
    for (int i = 0; i < 8; i++) wcoef(i, 1);
    for (int i = 0; i < 8; i++) send((i + 1) * 10);
    wait_out(8);
    for (int i = 0; i < 8 && i < got.size(); i++) begin
      chk("sum_dut", got[i], sums[i]);
      chk("sum_model", mres[i], sums[i]);
      chk("latency", out_cyc[i] - acc_cyc[i], TAPS + 1);
      if (i > 0) chk("accept_gap", acc_cyc[i] - acc_cyc[i-1], TAPS + 2);
    end
    do_reset();
    for (int i = 0; i < 8; i++) wcoef(i, int'(imp[i]));
    send(1);
    for (int i = 0; i < 7; i++) send(0);
    wait_out(8);
    for (int i = 0; i < 8 && i < got.size(); i++) begin
      chk("impulse_dut", got[i], imp[i]);
      chk("impulse_model", mres[i], imp[i]);
    end
    do_reset();
    for (int i = 0; i < 8; i++) wcoef(i, 127);
    for (int i = 0; i < 8; i++) send(127);
    for (int i = 0; i < 8; i++) send(-128);
    wait_out(16);
    if (got.size() >= 16) begin
      chk("sat_hi_dut", got[7], 32767);
      chk("sat_hi_model", mres[7], 32767);
      chk("sat_lo_dut", got[15], -32768);
      chk("sat_lo_model", mres[15], -32768);
    end
    do_reset();
    wcoef(0, 2);
    out_ready = 0;
    send(3);
    in_valid = 1; data_in = 11;
    n = 0;
    while (!out_valid && n < 50) begin tick(); n++; end
    chk("bp_reach_out", out_valid, 1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_hold", data_out, 6);
      chk("bp_valid", out_valid, 1);
      chk("bp_in_ready", in_ready, 0);
    end
    out_ready = 1;
    tick();
    chk("bp_idle_ready", in_ready, 1);
    chk("bp_idle_valid", out_valid, 0);
    tick();
    in_valid = 0;
    chk("bp_accepted", in_ready, 0);
    wait_out(2);
    if (got.size() >= 2) begin
      chk("bp_first", got[0], 6);
      chk("bp_second", got[1], 22);
    end
    do_reset();
    wcoef(0, 2);
    for (int i = 1; i < 8; i++) wcoef(i, 1);
    send(5);
    wcoef(0, 9);
    chk("cfg_err_set", coef_err, 1);
    wait_out(1);
    if (got.size() >= 1) chk("cfg_old_coef", got[0], 10);
    send_w(4, 0, 9);
    wait_out(2);
    if (got.size() >= 2) chk("cfg_new_coef", got[1], 41);
    chk("cfg_err_sticky", coef_err, 1);
    do_reset();
    for (int i = 0; i < 8; i++) wcoef(i, 3);
    send(7);
    wcoef(1, 4);
    tick(); tick();
    chk("mid_err", coef_err, 1);
    reset = 1;
    tick();
    reset = 0;
    chk("mid_in_ready", in_ready, 1);
    chk("mid_out_valid", out_valid, 0);
    chk("mid_coef_err", coef_err, 0);
    for (int i = 0; i < 8; i++) wcoef(i, 1);
    send(5);
    wait_out(1);
    if (got.size() >= 1) chk("mid_fresh", got[0], 5);
    do_reset();
    for (int i = 0; i < 8; i++) wcoef(i, int'($urandom_range(0, 255)) - 128);
    for (int c = 0; c < 800; c++) begin
      in_valid = 1'($urandom_range(0, 1));
      data_in = 8'($urandom);
      out_ready = $urandom_range(0, 3) != 0;
      coef_we = $urandom_range(0, 7) == 0;
      coef_addr = 3'($urandom);
      coef_data = 8'($urandom);
      tick();
    end
    in_valid = 0; coef_we = 0; out_ready = 1;
    for (int c = 0; c < 12; c++) tick();
    chk("rand_outputs", got.size() > 10, 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
